// File: rtl/md_unit_if.sv
// Handshake and result bundle between the EX-stage operand muxes and md_unit.
// The master side issues ops; the slave side (md_unit) reports busy and HI/LO.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: MULT(U), MADD(U), DIV(U), MTHI/MTLO.
// The result is computed from captured operands and committed when the latency counter expires.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  md_unit_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMadd  = 3'd4;
  localparam logic [2:0] OpMaddu = 3'd5;
  localparam logic [2:0] OpMthi  = 3'd6;
  localparam logic [2:0] OpMtlo  = 3'd7;

  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;

  logic               signed_op;
  logic               is_div;
  logic               div_zero;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, result;
  logic [WIDTH-1:0]   ua, ub, ub_safe, q_mag, r_mag, quo, rem;

  // Datapath: everything derives from the captured operands and the held HI/LO.
  always_comb begin
    signed_op = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpDiv);
    is_div    = (op_q == OpDiv) || (op_q == OpDivu);
    div_zero  = (b_q == '0);

    // Extending to 2*WIDTH makes a truncated product correct for both signednesses.
    ext_a = {{WIDTH{signed_op & a_q[WIDTH-1]}}, a_q};
    ext_b = {{WIDTH{signed_op & b_q[WIDTH-1]}}, b_q};
    prod  = ext_a * ext_b;

    a_neg   = signed_op & a_q[WIDTH-1];
    b_neg   = signed_op & b_q[WIDTH-1];
    ua      = a_neg ? -a_q : a_q;
    ub      = b_neg ? -b_q : b_q;
    ub_safe = (ub == '0) ? WIDTH'(1) : ub;
    q_mag   = ua / ub_safe;
    r_mag   = ua % ub_safe;
    // MIN_INT / -1 falls out naturally: magnitude 2^(WIDTH-1), no negation.
    quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem     = a_neg ? -r_mag : r_mag;

    unique case (op_q)
      OpMadd, OpMaddu: result = {hi_q, lo_q} + prod;
      OpDiv, OpDivu:   result = {rem, quo};
      default:         result = prod;
    endcase
  end

  always_comb begin
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;

    if (bus.cancel) begin
      count_d = '0;
    end else if (count_q != '0) begin
      count_d = count_q - CntW'(1);
      if (count_q == CntW'(1) && !(is_div && div_zero)) begin
        hi_d = result[2*WIDTH-1:WIDTH];
        lo_d = result[WIDTH-1:0];
      end
    end else if (bus.start) begin
      unique case (bus.op)
        OpMthi: hi_d = bus.a;
        OpMtlo: lo_d = bus.a;
        default: begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          count_d = (bus.op == OpDiv || bus.op == OpDivu) ? CntW'(DIV_CYCLES)
                                                          : CntW'(MULT_CYCLES);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OpMult;
    end else begin
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign bus.busy = (count_q != '0);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_md_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  md_unit_if #(.WIDTH(32)) mif ();

  md_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // Drives one start pulse; returns at the first falling edge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    mif.start = 1'b1;
    mif.op    = o;
    mif.a     = av;
    mif.b     = bv;
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  // Counts falling edges with busy high, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (mif.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    mif.start  = 1'b0;
    mif.op     = 3'd0;
    mif.a      = '0;
    mif.b      = '0;
    mif.cancel = 1'b0;
    #12;
    checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", mif.busy); end
    checks++; if (mif.hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h want 0", mif.hi); end
    checks++; if (mif.lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h want 0", mif.lo); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mult();
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'h00000003);
    checks++; if (mif.lo !== 32'h0) begin failures++; $display("FAIL mult_lo_during_busy: got %h want 0", mif.lo); end
    wait_idle(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    checks++; if (mif.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h want FFFFFFFF", mif.hi); end
    checks++; if (mif.lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo: got %h want FFFFFFFA", mif.lo); end
    issue(3'd1, 32'hFFFFFFFE, 32'h00000003);
    wait_idle(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    checks++; if (mif.hi !== 32'h00000002) begin failures++; $display("FAIL multu_hi: got %h want 00000002", mif.hi); end
    checks++; if (mif.lo !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo: got %h want FFFFFFFA", mif.lo); end
  endtask

  task automatic test_div();
    int n;
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL divu_busy_cycles: got %0d want 10", n); end
    checks++; if (mif.lo !== 32'h0000000E) begin failures++; $display("FAIL divu_lo: got %h want 0000000E", mif.lo); end
    checks++; if (mif.hi !== 32'h00000002) begin failures++; $display("FAIL divu_hi: got %h want 00000002", mif.hi); end
    issue(3'd2, 32'hFFFFFFF9, 32'h00000002);
    wait_idle(n);
    checks++; if (mif.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_neg_lo: got %h want FFFFFFFD", mif.lo); end
    checks++; if (mif.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_neg_hi: got %h want FFFFFFFF", mif.hi); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++; if (mif.lo !== 32'h80000000) begin failures++; $display("FAIL div_minint_lo: got %h want 80000000", mif.lo); end
    checks++; if (mif.hi !== 32'h00000000) begin failures++; $display("FAIL div_minint_hi: got %h want 00000000", mif.hi); end
  endtask

  task automatic test_div_zero();
    int n;
    issue(3'd6, 32'h00001234, 32'h0);
    checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL mthi_busy: got %b want 0", mif.busy); end
    checks++; if (mif.hi !== 32'h00001234) begin failures++; $display("FAIL mthi_hi: got %h want 00001234", mif.hi); end
    issue(3'd7, 32'h00005678, 32'h0);
    checks++; if (mif.lo !== 32'h00005678) begin failures++; $display("FAIL mtlo_lo: got %h want 00005678", mif.lo); end
    issue(3'd2, 32'd9, 32'd0);
    wait_idle(n);
    checks++; if (n !== 10) begin failures++; $display("FAIL divzero_busy_cycles: got %0d want 10", n); end
    checks++; if (mif.hi !== 32'h00001234) begin failures++; $display("FAIL divzero_hi: got %h want 00001234", mif.hi); end
    checks++; if (mif.lo !== 32'h00005678) begin failures++; $display("FAIL divzero_lo: got %h want 00005678", mif.lo); end
  endtask

  task automatic test_madd();
    int n;
    issue(3'd6, 32'h00000000, 32'h0);
    issue(3'd7, 32'hFFFFFFFF, 32'h0);
    issue(3'd5, 32'h00000001, 32'h00000001);
    wait_idle(n);
    checks++; if (n !== 5) begin failures++; $display("FAIL maddu_busy_cycles: got %0d want 5", n); end
    checks++; if (mif.hi !== 32'h00000001) begin failures++; $display("FAIL maddu_hi: got %h want 00000001", mif.hi); end
    checks++; if (mif.lo !== 32'h00000000) begin failures++; $display("FAIL maddu_lo: got %h want 00000000", mif.lo); end
    issue(3'd4, 32'hFFFFFFFF, 32'h00000001);
    wait_idle(n);
    checks++; if (mif.hi !== 32'h00000000) begin failures++; $display("FAIL madd_hi: got %h want 00000000", mif.hi); end
    checks++; if (mif.lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL madd_lo: got %h want FFFFFFFF", mif.lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(3'd0, 32'd3, 32'd4);
    // Two ignored starts while busy: a DIVU and an MTLO.
    mif.start = 1'b1; mif.op = 3'd3; mif.a = 32'd100; mif.b = 32'd7;
    @(negedge clk);
    mif.op = 3'd7; mif.a = 32'h0000DEAD;
    @(negedge clk);
    mif.start = 1'b0;
    wait_idle(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL b2b_busy_remaining: got %0d want 3", n); end
    checks++; if (mif.lo !== 32'h0000000C) begin failures++; $display("FAIL b2b_lo: got %h want 0000000C", mif.lo); end
    checks++; if (mif.hi !== 32'h00000000) begin failures++; $display("FAIL b2b_hi: got %h want 00000000", mif.hi); end
    @(negedge clk);
    checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL b2b_late_accept: got %b want 0", mif.busy); end
  endtask

  task automatic test_cancel();
    int n;
    issue(3'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    checks++; if (mif.busy !== 1'b1) begin failures++; $display("FAIL cancel_pre_busy: got %b want 1", mif.busy); end
    mif.cancel = 1'b1;
    @(negedge clk);
    mif.cancel = 1'b0;
    checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b want 0", mif.busy); end
    repeat (12) @(negedge clk);
    checks++; if (mif.lo !== 32'h0000000C) begin failures++; $display("FAIL cancel_lo: got %h want 0000000C", mif.lo); end
    checks++; if (mif.hi !== 32'h00000000) begin failures++; $display("FAIL cancel_hi: got %h want 00000000", mif.hi); end

    // Cancel exactly on the completion edge.
    issue(3'd1, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    mif.cancel = 1'b1;
    @(negedge clk);
    mif.cancel = 1'b0;
    wait_idle(n);
    checks++; if (mif.lo !== 32'h0000000C) begin failures++; $display("FAIL cancel_last_lo: got %h want 0000000C", mif.lo); end

    // Reset asserted between edges mid-operation.
    issue(3'd0, 32'd3, 32'd4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", mif.busy); end
    checks++; if (mif.lo !== 32'h0) begin failures++; $display("FAIL midreset_lo: got %h want 0", mif.lo); end
    @(negedge clk);
    reset = 1'b1;

    // cancel and start together: neither an MTHI nor a MULT may be accepted.
    issue(3'd6, 32'h00000055, 32'h0);
    @(negedge clk);
    mif.start = 1'b1; mif.op = 3'd6; mif.a = 32'h000000AA; mif.cancel = 1'b1;
    @(negedge clk);
    mif.op = 3'd0; mif.a = 32'd3; mif.b = 32'd4;
    @(negedge clk);
    mif.start = 1'b0; mif.cancel = 1'b0;
    checks++; if (mif.hi !== 32'h00000055) begin failures++; $display("FAIL cancel_start_hi: got %h want 00000055", mif.hi); end
    checks++; if (mif.busy !== 1'b0) begin failures++; $display("FAIL cancel_start_busy: got %b want 0", mif.busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_madd();
    test_back_to_back();
    test_cancel();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
